// File: rtl/score_display_ctrl_pkg.sv
// Shared constants and state type for the score display controller.
package score_display_ctrl_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Largest score that fits in four decimal digits
    localparam int unsigned BCD_MAX = 9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LATCH
    } state_t;

endpackage

// File: rtl/score_display_ctrl_if.sv
// Score handshake between the game-state logic and the display controller.
interface score_display_ctrl_if #(
    parameter int SCORE_W = 14
);
    logic               score_valid;
    logic               score_ready;
    logic [SCORE_W-1:0] score;

    modport master (output score_valid, output score, input score_ready);
    modport slave  (input score_valid, input score, output score_ready);
endinterface

// File: rtl/bcd_dabble_seq.sv
// Iterative shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
module bcd_dabble_seq #(
    parameter int SCORE_W = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin_in,
    output logic               done,
    output logic [15:0]        bcd
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SCORE_W - 1);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        bcd_adj;

    // Add 3 to every nibble that would overflow past 9 after doubling
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                      ? bcd_q[4*gi +: 4] + 4'd3
                                      : bcd_q[4*gi +: 4];
        end
    endgenerate

    // done is high during the final iteration so the caller can move on
    assign done = busy_q && (cnt_q == LAST_ITER);
    assign bcd  = bcd_q;

    // Load on start, otherwise adjust-then-shift while busy
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bin_d  = bin_in;
            bcd_d  = '0;
        end else if (busy_q) begin
            bcd_d = {bcd_adj[14:0], bin_q[SCORE_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
                busy_d = 1'b0;
            end
        end
    end

    // Converter state; a reset discards any partial result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
        end
    end

endmodule

// File: rtl/hexdecoder.sv
// Binary nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hexdecoder
    import score_display_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup; hex letters kept so the decoder stays general purpose
    always_comb begin
        seg = SEG_ZERO;
        case (digit)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_ZERO;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Accepts a binary score, converts it to BCD and drives four 7-segment digits
// with optional leading-zero blanking and whole-display blinking.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    score_display_ctrl_if.slave  sif,
    input  logic                 blank_lz,
    input  logic                 blink_en,
    output logic                 sat,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t             state_q, state_d;
    logic               sat_next_q, sat_next_d;
    logic               sat_q, sat_d;
    logic [3:0][3:0]    digit_q, digit_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    logic               conv_start;
    logic               conv_done;
    logic [15:0]        conv_bcd;
    logic               sat_hit;
    logic [SCORE_W-1:0] score_clamped;

    // Clamping first guarantees four BCD digits never overflow
    assign sat_hit       = (32'(sif.score) > BCD_MAX);
    assign score_clamped = sat_hit ? SCORE_W'(BCD_MAX) : sif.score;
    assign sif.score_ready = (state_q == IDLE);
    assign sat           = sat_q;

    bcd_dabble_seq #(.SCORE_W(SCORE_W)) u_dabble (
        .clock  (clock),
        .reset  (reset),
        .start  (conv_start),
        .bin_in (score_clamped),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    // Sequencer: accept, wait for the converter, then latch digits and sat
    always_comb begin
        state_d    = state_q;
        sat_next_d = sat_next_q;
        sat_d      = sat_q;
        digit_d    = digit_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (sif.score_valid) begin
                    conv_start = 1'b1;
                    sat_next_d = sat_hit;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                digit_d = conv_bcd;
                sat_d   = sat_next_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running blink divider; phase flips on every wrap
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // All controller state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sat_next_q    <= 1'b0;
            sat_q         <= 1'b0;
            digit_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sat_next_q    <= sat_next_d;
            sat_q         <= sat_d;
            digit_q       <= digit_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // lz_chain[i] is high when blanking is on and digits i..3 are all zero
    logic [4:1] lz_chain;
    logic [6:0] seg_raw [4];
    logic [6:0] hex_out [4];

    assign lz_chain[4] = blank_lz;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            hexdecoder u_hex (
                .digit (digit_q[gi]),
                .seg   (seg_raw[gi])
            );
            if (gi == 0) begin : g_ones
                // Ones digit always shows, except during the blink-off phase
                assign hex_out[gi] = (blink_en && blink_phase_q) ? SEG_BLANK : seg_raw[gi];
            end else begin : g_upper
                assign lz_chain[gi] = lz_chain[gi+1] && (digit_q[gi] == 4'd0);
                assign hex_out[gi]  = ((blink_en && blink_phase_q) || lz_chain[gi])
                                    ? SEG_BLANK : seg_raw[gi];
            end
        end
    endgenerate

    assign HEX0 = hex_out[0];
    assign HEX1 = hex_out[1];
    assign HEX2 = hex_out[2];
    assign HEX3 = hex_out[3];

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed plus randomized check of score_display_ctrl against a decimal
// reference model of what the four digits should show.
module tb_score_display_ctrl;

    localparam int SCORE_W   = 14;
    localparam int BLINK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       blank_lz = 1'b1;
    logic       blink_en = 1'b0;
    logic       sat;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    score_display_ctrl_if #(.SCORE_W(SCORE_W)) sif ();

    score_display_ctrl #(
        .SCORE_W   (SCORE_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sif      (sif),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .sat      (sat),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    always #5 clock = ~clock;

    // Rising edges seen since reset was released
    int edges = 0;
    always @(posedge clock or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   disp_val = 0;
    logic sat_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'hxx;
        endcase
    endfunction

    function automatic int pow10(input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        return p;
    endfunction

    // Expected pattern for digit i from the shown decimal value and controls
    function automatic logic [6:0] exp_hex(input int i);
        int p;
        p = pow10(i);
        if (blink_en && (((edges / BLINK_DIV) % 2) == 1)) return 7'h7F;
        if (blank_lz && (i > 0) && (disp_val < p)) return 7'h7F;
        return seg_of((disp_val / p) % 10);
    endfunction

    task automatic check_display(input string tag);
        chk({tag, "_hex0"}, HEX0, exp_hex(0));
        chk({tag, "_hex1"}, HEX1, exp_hex(1));
        chk({tag, "_hex2"}, HEX2, exp_hex(2));
        chk({tag, "_hex3"}, HEX3, exp_hex(3));
        chk({tag, "_sat"},  sat,  sat_exp);
    endtask

    // Present val while ready; follow the accept edge through the latch edge.
    // With hold set, score_valid stays high after acceptance.
    task automatic run_conversion(input int val, input bit hold);
        sif.score       = SCORE_W'(val);
        sif.score_valid = 1'b1;
        #1;
        chk("ready_pre", sif.score_ready, 1'b1);
        @(posedge clock);
        for (int k = 0; k <= SCORE_W + 1; k++) begin
            @(negedge clock);
            if (k == 0 && !hold) sif.score_valid = 1'b0;
            #1;
            if (k == SCORE_W + 1) begin
                disp_val = (val > 9999) ? 9999 : val;
                sat_exp  = (val > 9999);
            end
            chk("ready_conv", sif.score_ready, (k == SCORE_W + 1));
            check_display("conv");
        end
        $display("txn score=%0d shown=%0d sat=%0b blank_lz=%0b blink_en=%0b hex=%h %h %h %h",
                 val, disp_val, sat, blank_lz, blink_en, HEX3, HEX2, HEX1, HEX0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  val;
        bit  hold;

        sif.score_valid = 1'b0;
        sif.score       = '0;

        // Reset values with leading-zero blanking on, then off
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_ready", sif.score_ready, 1'b1);
        chk("rst_sat",   sat,  1'b0);
        chk("rst_hex0",  HEX0, 7'h40);
        chk("rst_hex1",  HEX1, 7'h7F);
        chk("rst_hex2",  HEX2, 7'h7F);
        chk("rst_hex3",  HEX3, 7'h7F);
        blank_lz = 1'b0;
        #1;
        chk("rst_nolz_hex3", HEX3, 7'h40);
        check_display("rst");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_display("rst_rel");

        // 1234 appears exactly after the latch edge
        run_conversion(1234, 1'b0);
        chk("d1234_hex3", HEX3, 7'h79);
        chk("d1234_hex2", HEX2, 7'h24);
        chk("d1234_hex1", HEX1, 7'h30);
        chk("d1234_hex0", HEX0, 7'h19);

        // Saturation then a small score clears sat
        run_conversion(12000, 1'b0);
        chk("sat_hex3", HEX3, 7'h10);
        chk("sat_hex0", HEX0, 7'h10);
        chk("sat_flag", sat, 1'b1);
        run_conversion(7, 1'b0);
        chk("seven_sat",  sat,  1'b0);
        chk("seven_hex0", HEX0, 7'h78);
        chk("seven_hex3", HEX3, 7'h40);

        // Leading-zero toggle acts in the same cycle
        blank_lz = 1'b1;
        #1;
        chk("lz_hex3", HEX3, 7'h7F);
        chk("lz_hex2", HEX2, 7'h7F);
        chk("lz_hex1", HEX1, 7'h7F);
        chk("lz_hex0", HEX0, 7'h78);
        blank_lz = 1'b0;

        // Back-to-back with score_valid held: second accept 16 edges later
        run_conversion(42, 1'b1);
        run_conversion(43, 1'b0);

        // Reset at iteration 5 of a conversion discards it
        run_conversion(12000, 1'b0);
        sif.score       = SCORE_W'(555);
        sif.score_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        sif.score_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        disp_val = 0;
        sat_exp  = 1'b0;
        chk("midrst_ready", sif.score_ready, 1'b1);
        check_display("midrst");
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            check_display("midrst_after");
        end
        chk("midrst_ready_after", sif.score_ready, 1'b1);

        // Randomized scores and display controls
        for (int t = 0; t < 10; t++) begin
            blank_lz = 1'($urandom_range(0, 1));
            blink_en = 1'($urandom_range(0, 1));
            hold     = 1'($urandom_range(0, 1));
            val      = (t % 2 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
            run_conversion(val, hold);
        end
        sif.score_valid = 1'b0;
        blink_en = 1'b0;
        blank_lz = 1'b0;

        // Blink: fresh reset so the phase starts visible, then show 1234
        @(negedge clock);
        reset = 1'b1;
        #1;
        disp_val = 0;
        sat_exp  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_conversion(1234, 1'b0);
        blink_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            #1;
            check_display("blink");
        end
        blink_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            #1;
            check_display("noblink");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
